pingpong_ball_ctrl: RTL and testbench
=====================================

Name: pingpong_ball_ctrl

Overview:
- Consumer end of the game tick. The clock divider emits a one-cycle `tick` pulse; this block turns ticks and player button pulses into ball motion on an LED row.
- Owns the rally state machine, both score counters and game-over detection.
- Sits between the tick divider / button debouncers and the LED and score display drivers.

Parameters:
- N_LEDS, 8, number of ball positions; 4 minimum.
- SCORE_W, 4, score counter width; must hold WIN_SCORE.
- WIN_SCORE, 7, score that ends the game.
- POINT_TICKS, 3, ticks the point-flash pattern is held.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high. One clock; all state clears on the clk edge where reset=1.
- tick, input, 1, one-cycle enable pulse from the divider; the only time base for motion.
- btn_l, input, 1, left paddle; debounced single-cycle pulse.
- btn_r, input, 1, right paddle; debounced single-cycle pulse.
- leds, output, N_LEDS, ball/pattern display; bit 0 = leftmost.
- score_l, output, SCORE_W, left player score.
- score_r, output, SCORE_W, right player score.
- game_over, output, 1, high while in OVER.
- winner, output, 1, 0 = left won, 1 = right won; valid only while game_over=1.

Behaviour:
- All outputs and state registered; inputs sampled on posedge clk.
- Reset values:
  - state=IDLE, serve_side=left, pos=0
  - leds=1 (bit 0 set)
  - scores=0, game_over=0, winner=0
  - flash counter=0
- leds encoding:
  - IDLE/MOVE_R/MOVE_L: one-hot at pos.
  - POINT: all ones.
  - OVER: alternating 0101… pattern, LSB=1.
- IDLE:
  - pos = 0 if serve_side=left, else N_LEDS-1.
  - Serving player's button → MOVE_R (left serve) or MOVE_L (right serve). pos is unchanged that cycle.
  - Other player's button is ignored. Ticks are ignored.
- MOVE_R:
  - tick with pos<N_LEDS-1 → pos+1.
  - btn_r with pos==N_LEDS-1 → MOVE_L (return). pos unchanged; the next tick gives pos-1.
  - btn_r with pos<N_LEDS-1 → early swing: left scores, enter POINT.
  - tick with pos==N_LEDS-1 and no btn_r → miss: left scores, enter POINT.
  - btn_l is ignored.
- MOVE_L: mirror image of MOVE_R (pos-1, return at pos==0 with btn_l, right scores on a fault).
- Simultaneous events:
  - Button beats tick in the same cycle. A return and a tick at the end position is a valid return, not a miss.
  - btn_l and btn_r in the same cycle are each evaluated per the rules above; the ignored side has no effect.
- Scoring:
  - Score increments on the POINT entry edge.
  - Loser of the point becomes serve_side.
  - Scores never wrap; they stop at WIN_SCORE because OVER is entered.
- POINT:
  - Hold all-ones for POINT_TICKS ticks (counter counts ticks, not clocks).
  - On the final tick: if either score==WIN_SCORE → OVER with winner set; else → IDLE.
  - Buttons are ignored.
- OVER:
  - game_over=1.
  - Any btn_l or btn_r pulse → scores=0, serve_side=left, pos=0, state IDLE, game_over=0.
- Latency: a state or pos change is visible on outputs one clk after the sampling edge.
- Reset mid-rally or mid-flash: immediate return to reset values next edge; no partial score update.
- tick held high for multiple cycles: each high cycle counts as one tick (no edge detection).

Optional Feature:
- Macro: PINGPONG_SPEEDUP_EN.
- Defined:
  - An internal 1-bit prescaler makes the ball step only on every second tick for the first 4 returns of a rally; afterwards it steps on every tick.
  - Return count and prescaler clear on POINT entry, on IDLE serve and on reset.
  - Miss detection uses the same gated step: a miss is taken only on a step-enabled tick.
- Not defined: ball steps on every tick; no return counter or prescaler logic exists.
- POINT_TICKS counting uses the raw tick in both cases.

Test Plan:
- Reset then 9 ticks, no buttons → state stays IDLE, leds=8'h01, scores 0, game_over=0.
- btn_l in IDLE, then 7 ticks → leds steps 01,02,…,80. 8th tick with no btn_r → score_l=1; leds=FF for 3 ticks; then IDLE with leds=8'h80 (right serves).
- Ball at pos 7 in MOVE_R; btn_r and tick in the same cycle → return, no score change; next tick gives leds=8'h40.
- btn_r while ball at pos 4 in MOVE_R → early swing: score_l increments, POINT entered.
- Drive left to 7 points → after the flash, game_over=1, winner=0, leds=8'h55. btn_r → scores 0, IDLE, leds=8'h01.
- Assert reset mid-POINT flash with score_l=3 → next cycle score_l=0, leds=8'h01, flash aborted.
- With PINGPONG_SPEEDUP_EN: first serve needs 14 ticks to reach pos 7. After the 4th return, the ball steps every tick.

Source files
------------

// File: rtl/pingpong_ball_ctrl.sv
// Pong rally controller: turns divider ticks and paddle pulses into ball motion, scores and game-over.
// Optional macro PINGPONG_SPEEDUP_EN halves the ball speed for the first 4 returns of each rally.
module pingpong_ball_ctrl #(
    parameter int N_LEDS      = 8,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 7,
    parameter int POINT_TICKS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               btn_l,
    input  logic               btn_r,
    output logic [N_LEDS-1:0]  leds,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over,
    output logic               winner
);

    localparam int PW = $clog2(N_LEDS);
    localparam int FW = (POINT_TICKS > 1) ? $clog2(POINT_TICKS) : 1;
    localparam logic [PW-1:0]      LAST_POS   = PW'(N_LEDS - 1);
    localparam logic [FW-1:0]      LAST_FLASH = FW'(POINT_TICKS - 1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
    localparam logic [N_LEDS-1:0]  OVER_PAT   = N_LEDS'({N_LEDS{2'b01}});

    typedef enum logic [2:0] {S_IDLE, S_MOVE_R, S_MOVE_L, S_POINT, S_OVER} state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic               serve_q, serve_d;   // 1 = right player serves
    logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic [FW-1:0]      flash_q, flash_d;
    logic               winner_q, winner_d;
    logic               over_q;
    logic [N_LEDS-1:0]  leds_q, leds_d;
    logic               point_l, point_r;
    logic               step;

`ifdef PINGPONG_SPEEDUP_EN
    logic       presc_q, presc_d;
    logic [2:0] ret_q, ret_d;

    assign step = tick && (presc_q || ret_q == 3'd4);

    always_comb begin
        presc_d = presc_q;
        ret_d   = ret_q;
        if ((state_q == S_MOVE_R || state_q == S_MOVE_L) && tick && ret_q != 3'd4)
            presc_d = ~presc_q;
        if (((state_q == S_MOVE_R && btn_r && pos_q == LAST_POS) ||
             (state_q == S_MOVE_L && btn_l && pos_q == '0)) && ret_q != 3'd4)
            ret_d = ret_q + 3'd1;
        if ((state_q == S_IDLE && state_d != S_IDLE) ||
            (state_q != S_POINT && state_d == S_POINT)) begin
            presc_d = 1'b0;
            ret_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= 1'b0;
            ret_q   <= '0;
        end else begin
            presc_q <= presc_d;
            ret_q   <= ret_d;
        end
    end
`else
    assign step = tick;
`endif

    // NOTE: every output defaults to its held value first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        serve_d   = serve_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        flash_d   = flash_q;
        winner_d  = winner_q;
        point_l   = 1'b0;
        point_r   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!serve_q && btn_l)     state_d = S_MOVE_R;
                else if (serve_q && btn_r) state_d = S_MOVE_L;
            end
            S_MOVE_R: begin
                if (btn_r) begin
                    if (pos_q == LAST_POS) state_d = S_MOVE_L;
                    else                   point_l = 1'b1;
                end else if (step) begin
                    if (pos_q != LAST_POS) pos_d   = pos_q + PW'(1);
                    else                   point_l = 1'b1;
                end
            end
            S_MOVE_L: begin
                if (btn_l) begin
                    if (pos_q == '0) state_d = S_MOVE_R;
                    else             point_r = 1'b1;
                end else if (step) begin
                    if (pos_q != '0) pos_d   = pos_q - PW'(1);
                    else             point_r = 1'b1;
                end
            end
            S_POINT: begin
                if (tick) begin
                    if (flash_q == LAST_FLASH) begin
                        flash_d = '0;
                        if (score_l_q == WIN || score_r_q == WIN) begin
                            state_d  = S_OVER;
                            winner_d = (score_r_q == WIN);
                        end else begin
                            state_d = S_IDLE;
                            pos_d   = serve_q ? LAST_POS : '0;
                        end
                    end else begin
                        flash_d = flash_q + FW'(1);
                    end
                end
            end
            S_OVER: begin
                if (btn_l || btn_r) begin
                    state_d   = S_IDLE;
                    pos_d     = '0;
                    serve_d   = 1'b0;
                    score_l_d = '0;
                    score_r_d = '0;
                    winner_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The loser of the point serves next.
        if (point_l) begin
            score_l_d = score_l_q + SCORE_W'(1);
            serve_d   = 1'b1;
            state_d   = S_POINT;
            flash_d   = '0;
        end
        if (point_r) begin
            score_r_d = score_r_q + SCORE_W'(1);
            serve_d   = 1'b0;
            state_d   = S_POINT;
            flash_d   = '0;
        end

        leds_d = '0;
        case (state_d)
            S_POINT: leds_d = '1;
            S_OVER:  leds_d = OVER_PAT;
            default: leds_d[pos_d] = 1'b1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pos_q     <= '0;
            serve_q   <= 1'b0;
            score_l_q <= '0;
            score_r_q <= '0;
            flash_q   <= '0;
            winner_q  <= 1'b0;
            over_q    <= 1'b0;
            leds_q    <= N_LEDS'(1);
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            serve_q   <= serve_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            flash_q   <= flash_d;
            winner_q  <= winner_d;
            over_q    <= (state_d == S_OVER);
            leds_q    <= leds_d;
        end
    end

    assign leds      = leds_q;
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign game_over = over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_pingpong_ball_ctrl.sv
// Directed bench for pingpong_ball_ctrl: rally motion, returns, faults, flash, game over and reset.
module tb_pingpong_ball_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       btn_l = 1'b0;
    logic       btn_r = 1'b0;
    logic [7:0] leds;
    logic [3:0] score_l, score_r;
    logic       game_over, winner;

    int checks = 0;
    int errors = 0;
    bit serve_right = 1'b0;

    pingpong_ball_ctrl dut (
        .clk(clk), .reset(reset), .tick(tick), .btn_l(btn_l), .btn_r(btn_r),
        .leds(leds), .score_l(score_l), .score_r(score_r),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic t, input logic l, input logic r);
        tick = t; btn_l = l; btn_r = r;
        @(posedge clk);
        #1;
        tick = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    // Plays one point to the fault; the flash is optionally completed.
    task automatic play_point(input bit left_wins, input bit right_serves, input bit do_flash);
        if (right_serves) begin
            cyc(1'b0, 1'b0, 1'b1);
            if (left_wins) begin
                ticks(7);
                cyc(1'b0, 1'b1, 1'b0);
                cyc(1'b0, 1'b0, 1'b1);
            end else begin
                cyc(1'b0, 1'b1, 1'b0);
            end
        end else begin
            cyc(1'b0, 1'b1, 1'b0);
            if (left_wins) begin
                cyc(1'b0, 1'b0, 1'b1);
            end else begin
                ticks(7);
                cyc(1'b0, 1'b0, 1'b1);
                cyc(1'b0, 1'b1, 1'b0);
            end
        end
        if (do_flash) ticks(3);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        checks++; if (leds !== 8'h01) begin errors++; $display("FAIL reset_leds got %h want 01", leds); end
        checks++; if (score_l !== 4'd0 || score_r !== 4'd0) begin errors++; $display("FAIL reset_scores got %0d/%0d want 0/0", score_l, score_r); end
        checks++; if (game_over !== 1'b0 || winner !== 1'b0) begin errors++; $display("FAIL reset_over got %b/%b want 0/0", game_over, winner); end
        ticks(9);
        checks++; if (leds !== 8'h01) begin errors++; $display("FAIL idle_ticks_leds got %h want 01", leds); end
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (leds !== 8'h01 || score_l !== 4'd0 || score_r !== 4'd0 || game_over !== 1'b0) begin
            errors++; $display("FAIL idle_wrong_btn got leds %h scores %0d/%0d over %b want 01 0/0 0", leds, score_l, score_r, game_over);
        end
    endtask

    task automatic test_serve_miss();
        cyc(1'b0, 1'b1, 1'b0);
        checks++; if (leds !== 8'h01) begin errors++; $display("FAIL serve_pos_hold got %h want 01", leds); end
        for (int i = 1; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            checks++; if (leds !== 8'(1 << i)) begin errors++; $display("FAIL step_r_%0d got %h want %h", i, leds, 8'(1 << i)); end
        end
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (score_l !== 4'd1 || score_r !== 4'd0 || leds !== 8'hFF) begin
            errors++; $display("FAIL miss_r got scores %0d/%0d leds %h want 1/0 FF", score_l, score_r, leds);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            checks++; if (leds !== 8'hFF) begin errors++; $display("FAIL flash_hold_%0d got %h want FF", i, leds); end
        end
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (leds !== 8'h80 || score_l !== 4'd1) begin errors++; $display("FAIL flash_end got leds %h score_l %0d want 80 1", leds, score_l); end
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (leds !== 8'h80) begin errors++; $display("FAIL idle_right_serve got %h want 80", leds); end
    endtask

    task automatic test_return();
        cyc(1'b0, 1'b0, 1'b1);
        checks++; if (leds !== 8'h80) begin errors++; $display("FAIL serve_r_hold got %h want 80", leds); end
        for (int i = 1; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            checks++; if (leds !== 8'(8'h80 >> i)) begin errors++; $display("FAIL step_l_%0d got %h want %h", i, leds, 8'(8'h80 >> i)); end
        end
        cyc(1'b1, 1'b1, 1'b0);
        checks++; if (leds !== 8'h01 || score_l !== 4'd1 || score_r !== 4'd0) begin
            errors++; $display("FAIL return_l_tick got leds %h scores %0d/%0d want 01 1/0", leds, score_l, score_r);
        end
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (leds !== 8'h02) begin errors++; $display("FAIL after_return_l got %h want 02", leds); end
        cyc(1'b0, 1'b1, 1'b0);
        checks++; if (leds !== 8'h02 || score_r !== 4'd0) begin errors++; $display("FAIL btn_l_ignored got leds %h score_r %0d want 02 0", leds, score_r); end
        ticks(6);
        checks++; if (leds !== 8'h80) begin errors++; $display("FAIL reach_end_r got %h want 80", leds); end
        cyc(1'b1, 1'b0, 1'b1);
        checks++; if (leds !== 8'h80 || score_l !== 4'd1 || score_r !== 4'd0) begin
            errors++; $display("FAIL return_r_tick got leds %h scores %0d/%0d want 80 1/0", leds, score_l, score_r);
        end
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (leds !== 8'h40) begin errors++; $display("FAIL after_return_r got %h want 40", leds); end
    endtask

    task automatic test_early_swing();
        ticks(6);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(4);
        checks++; if (leds !== 8'h10) begin errors++; $display("FAIL pos4 got %h want 10", leds); end
        cyc(1'b0, 1'b0, 1'b1);
        checks++; if (score_l !== 4'd2 || score_r !== 4'd0 || leds !== 8'hFF) begin
            errors++; $display("FAIL early_swing got scores %0d/%0d leds %h want 2/0 FF", score_l, score_r, leds);
        end
        cyc(1'b0, 1'b1, 1'b1);
        checks++; if (leds !== 8'hFF || score_l !== 4'd2 || score_r !== 4'd0) begin
            errors++; $display("FAIL point_btn_ignored got leds %h scores %0d/%0d want FF 2/0", leds, score_l, score_r);
        end
        ticks(3);
        checks++; if (leds !== 8'h80) begin errors++; $display("FAIL early_flash_end got %h want 80", leds); end
        serve_right = 1'b1;
    endtask

    task automatic test_game_over_left();
        for (int k = 3; k <= 7; k++) begin
            play_point(1'b1, serve_right, 1'b1);
            serve_right = 1'b1;
            checks++; if (score_l !== 4'(k)) begin errors++; $display("FAIL score_l_%0d got %0d want %0d", k, score_l, k); end
        end
        checks++; if (game_over !== 1'b1 || winner !== 1'b0 || leds !== 8'h55 || score_r !== 4'd0) begin
            errors++; $display("FAIL over_left got over %b winner %b leds %h score_r %0d want 1 0 55 0", game_over, winner, leds, score_r);
        end
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (game_over !== 1'b1 || leds !== 8'h55) begin errors++; $display("FAIL over_tick got over %b leds %h want 1 55", game_over, leds); end
        cyc(1'b0, 1'b0, 1'b1);
        checks++; if (game_over !== 1'b0 || leds !== 8'h01 || score_l !== 4'd0 || score_r !== 4'd0) begin
            errors++; $display("FAIL over_exit_r got over %b leds %h scores %0d/%0d want 0 01 0/0", game_over, leds, score_l, score_r);
        end
        serve_right = 1'b0;
    endtask

    task automatic test_game_over_right();
        for (int k = 1; k <= 7; k++) begin
            play_point(1'b0, 1'b0, 1'b1);
            checks++; if (score_r !== 4'(k) || score_l !== 4'd0) begin
                errors++; $display("FAIL score_r_%0d got %0d/%0d want 0/%0d", k, score_l, score_r, k);
            end
        end
        checks++; if (game_over !== 1'b1 || winner !== 1'b1 || leds !== 8'h55) begin
            errors++; $display("FAIL over_right got over %b winner %b leds %h want 1 1 55", game_over, winner, leds);
        end
        cyc(1'b0, 1'b1, 1'b0);
        checks++; if (game_over !== 1'b0 || leds !== 8'h01 || score_r !== 4'd0) begin
            errors++; $display("FAIL over_exit_l got over %b leds %h score_r %0d want 0 01 0", game_over, leds, score_r);
        end
    endtask

    task automatic test_reset_mid_flash();
        play_point(1'b1, 1'b0, 1'b1);
        play_point(1'b1, 1'b1, 1'b1);
        play_point(1'b1, 1'b1, 1'b0);
        checks++; if (score_l !== 4'd3 || leds !== 8'hFF) begin errors++; $display("FAIL pre_reset got score_l %0d leds %h want 3 FF", score_l, leds); end
        cyc(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        checks++; if (score_l !== 4'd0 || score_r !== 4'd0 || leds !== 8'h01 || game_over !== 1'b0) begin
            errors++; $display("FAIL mid_flash_reset got scores %0d/%0d leds %h over %b want 0/0 01 0", score_l, score_r, leds, game_over);
        end
        ticks(3);
        checks++; if (leds !== 8'h01) begin errors++; $display("FAIL flash_aborted got %h want 01", leds); end
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (leds !== 8'h02) begin errors++; $display("FAIL serve_after_reset got %h want 02", leds); end
    endtask

`ifdef PINGPONG_SPEEDUP_EN
    task automatic test_speedup();
        cyc(1'b0, 1'b1, 1'b0);
        ticks(13);
        checks++; if (leds !== 8'h40) begin errors++; $display("FAIL slow_13 got %h want 40", leds); end
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (leds !== 8'h80) begin errors++; $display("FAIL slow_14 got %h want 80", leds); end
        for (int r = 1; r <= 3; r++) begin
            cyc(1'b0, r[0] ? 1'b0 : 1'b1, r[0] ? 1'b1 : 1'b0);
            ticks(14);
            checks++; if (leds !== (r[0] ? 8'h01 : 8'h80)) begin errors++; $display("FAIL slow_ret_%0d got %h want %h", r, leds, r[0] ? 8'h01 : 8'h80); end
        end
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (leds !== 8'h02) begin errors++; $display("FAIL fast_1 got %h want 02", leds); end
        cyc(1'b1, 1'b0, 1'b0);
        checks++; if (leds !== 8'h04) begin errors++; $display("FAIL fast_2 got %h want 04", leds); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef PINGPONG_SPEEDUP_EN
        test_speedup();
`else
        test_serve_miss();
        test_return();
        test_early_swing();
        test_game_over_left();
        test_game_over_right();
        test_reset_mid_flash();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
